pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 32 +++
 rtl/ret_stack.sv | 49 ++++
 rtl/pc_unit.sv | 97 +++++++++
 tb/tb_pc_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM states and the
// control-priority encoding used to pick the next PC source.
package pc_pkg;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

   typedef enum logic [2:0] {
      CTL_INC,
      CTL_JUMP,
      CTL_CALL,
      CTL_RET,
      CTL_HALT
   } ctl_t;

   // Fixed priority: HALT > RET > CALL > TAKEN > increment.
   function automatic ctl_t resolve_ctl(input logic halt,
                                        input logic ret,
                                        input logic call,
                                        input logic taken);
      ctl_t c;
      if (halt)       c = CTL_HALT;
      else if (ret)   c = CTL_RET;
      else if (call)  c = CTL_CALL;
      else if (taken) c = CTL_JUMP;
      else            c = CTL_INC;
      return c;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack. Push is dropped when full, pop when empty;
// dout always presents the top entry (stack[sp-1]).
module ret_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     sp,
   output logic                       full,
   output logic                       empty
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             do_push;
   logic             do_pop;

   assign full    = (sp == SPW'(DEPTH));
   assign empty   = (sp == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wr_idx  = sp[AW-1:0];
   assign rd_idx  = AW'(sp - SPW'(1));
   assign dout    = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_pop) begin
         sp <= sp - SPW'(1);
      end else if (do_push) begin
         mem[wr_idx] <= din;
         sp          <= sp + SPW'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: RUN/HALTED FSM, next-PC selection with
// HALT > RET > CALL > TAKEN > increment priority, return stack, sticky flags.
module pc_unit
   import pc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int STEP  = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     EN,
   input  logic                     TAKEN,
   input  logic [WIDTH-1:0]         TARGET,
   input  logic                     CALL,
   input  logic                     RET,
   input  logic                     HALT,
   output logic [WIDTH-1:0]         PC,
   output logic [$clog2(DEPTH):0]   SP,
   output logic                     OVF,
   output logic                     UNF,
   output logic                     HALTED
);

   state_t           state, state_nxt;
   ctl_t             ctl;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] top;
   logic             push, pop, set_ovf, set_unf;
   logic             full, empty;

   assign pc_inc = PC + WIDTH'(STEP);
   assign ctl    = resolve_ctl(HALT, RET, CALL, TAKEN);
   assign HALTED = (state == ST_HALTED);

   ret_stack #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_stack (
      .clk  (CLK),
      .rst_n(RST_N),
      .push (push),
      .pop  (pop),
      .din  (pc_inc),
      .dout (top),
      .sp   (SP),
      .full (full),
      .empty(empty)
   );

   always_comb begin
      state_nxt = state;
      pc_nxt    = PC;
      push      = 1'b0;
      pop       = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      if (state == ST_RUN && EN) begin
         unique case (ctl)
            CTL_HALT: state_nxt = ST_HALTED;
            CTL_RET: begin
               if (empty) begin
                  set_unf = 1'b1;
                  pc_nxt  = pc_inc;
               end else begin
                  pop    = 1'b1;
                  pc_nxt = top;
               end
            end
            CTL_CALL: begin
               // Overflowing call still jumps; only the push is lost.
               if (full) set_ovf = 1'b1;
               else      push    = 1'b1;
               pc_nxt = TARGET;
            end
            CTL_JUMP: pc_nxt = TARGET;
            default:  pc_nxt = pc_inc;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_RUN;
         PC    <= '0;
         OVF   <= 1'b0;
         UNF   <= 1'b0;
      end else begin
         state <= state_nxt;
         PC    <= pc_nxt;
         if (set_ovf) OVF <= 1'b1;
         if (set_unf) UNF <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       EN, TAKEN, CALL, RET, HALT;
   logic [7:0] TARGET;
   logic [7:0] PC;
   logic [3:0] SP;
   logic       OVF, UNF, HALTED;

   int n_cmp = 0;
   int n_bad = 0;

   pc_unit #(.WIDTH(8), .DEPTH(8), .STEP(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (EN),
      .TAKEN (TAKEN),
      .TARGET(TARGET),
      .CALL  (CALL),
      .RET   (RET),
      .HALT  (HALT),
      .PC    (PC),
      .SP    (SP),
      .OVF   (OVF),
      .UNF   (UNF),
      .HALTED(HALTED)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one set of controls for one rising edge, sample 1 time unit later.
   task automatic step(input logic en, input logic taken, input logic [7:0] tgt,
                       input logic call, input logic ret, input logic halt);
      EN = en; TAKEN = taken; TARGET = tgt; CALL = call; RET = ret; HALT = halt;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      EN = 1'b0; TAKEN = 1'b0; TARGET = 8'h00; CALL = 1'b0; RET = 1'b0; HALT = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   task automatic check_state(input string tag, input logic [7:0] pc, input logic [3:0] sp,
                              input logic ovf, input logic unf, input logic halted);
      check({tag, ".pc"}, 32'(PC), 32'(pc));
      check({tag, ".sp"}, 32'(SP), 32'(sp));
      check({tag, ".ovf"}, 32'(OVF), 32'(ovf));
      check({tag, ".unf"}, 32'(UNF), 32'(unf));
      check({tag, ".halted"}, 32'(HALTED), 32'(halted));
   endtask

   initial begin
      idle_inputs();
      RST_N = 1'b0;
      #12;
      check_state("reset", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      RST_N = 1'b1;

      // Sequential increment, then a stall with live controls
      step(1, 0, 8'h00, 0, 0, 0); check("inc1", 32'(PC), 32'h04);
      step(1, 0, 8'h00, 0, 0, 0); check("inc2", 32'(PC), 32'h08);
      step(1, 0, 8'h00, 0, 0, 0); check("inc3", 32'(PC), 32'h0C);
      step(0, 1, 8'h55, 1, 0, 0); check("stall1", 32'(PC), 32'h0C);
      step(0, 0, 8'h00, 0, 1, 0); check_state("stall2", 8'h0C, 4'd0, 1'b0, 1'b0, 1'b0);

      // Wrap from 0xFC to 0x00
      step(1, 1, 8'hFC, 0, 0, 0); check("jmp_fc", 32'(PC), 32'hFC);
      step(1, 0, 8'h00, 0, 0, 0); check_state("wrap", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

      // Jump, call, return
      step(1, 1, 8'h10, 0, 0, 0); check("jmp10", 32'(PC), 32'h10);
      step(1, 1, 8'h40, 0, 0, 0); check("jmp40", 32'(PC), 32'h40);
      step(1, 0, 8'h80, 1, 0, 0); check("call80", 32'(PC), 32'h80); check("call80.sp", 32'(SP), 1);
      step(1, 0, 8'h00, 0, 1, 0); check("ret44", 32'(PC), 32'h44); check("ret44.sp", 32'(SP), 0);

      // Nested calls return in LIFO order
      do_reset();
      step(1, 0, 8'h40, 1, 0, 0); check("nest.c1", 32'(PC), 32'h40);
      step(1, 0, 8'h80, 1, 0, 0); check("nest.c2", 32'(PC), 32'h80); check("nest.sp", 32'(SP), 2);
      step(1, 0, 8'h00, 0, 1, 0); check("nest.r1", 32'(PC), 32'h44);
      step(1, 0, 8'h00, 0, 1, 0); check("nest.r2", 32'(PC), 32'h04);

      // Fill the stack, overflow, drain, underflow
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 8'h20, 1, 0, 0);
         check($sformatf("fill%0d.sp", i), 32'(SP), 32'(i));
      end
      check_state("full", 8'h20, 4'd8, 1'b0, 1'b0, 1'b0);
      step(1, 0, 8'h20, 1, 0, 0); check_state("ovf", 8'h20, 4'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 1; i--) begin
         step(1, 0, 8'h00, 0, 1, 0);
         check($sformatf("drain%0d.pc", i), 32'(PC), 32'h24);
         check($sformatf("drain%0d.sp", i), 32'(SP), 32'(i));
      end
      step(1, 0, 8'h00, 0, 1, 0); check_state("drain0", 8'h04, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1, 0, 8'h00, 0, 1, 0); check_state("unf", 8'h08, 4'd0, 1'b1, 1'b1, 1'b0);
      step(1, 0, 8'h00, 0, 0, 0); check_state("sticky", 8'h0C, 4'd0, 1'b1, 1'b1, 1'b0);

      // RET beats CALL and TAKEN in the same cycle
      do_reset();
      step(1, 1, 8'h2C, 0, 0, 0); check("pri.jmp", 32'(PC), 32'h2C);
      step(1, 0, 8'h60, 1, 0, 0); check("pri.call", 32'(PC), 32'h60); check("pri.sp1", 32'(SP), 1);
      step(1, 1, 8'h90, 1, 1, 0); check_state("pri.ret", 8'h30, 4'd0, 1'b0, 1'b0, 1'b0);

      // HALT overrides everything and freezes state
      do_reset();
      step(1, 1, 8'h20, 0, 0, 0);
      step(1, 0, 8'h24, 1, 0, 0); check("h.pre", 32'(PC), 32'h24);
      step(1, 1, 8'h70, 1, 1, 1); check_state("halt", 8'h24, 4'd1, 1'b0, 1'b0, 1'b1);
      step(1, 1, 8'h70, 0, 0, 0); check_state("halt.t1", 8'h24, 4'd1, 1'b0, 1'b0, 1'b1);
      step(1, 0, 8'h00, 0, 1, 0); check_state("halt.t2", 8'h24, 4'd1, 1'b0, 1'b0, 1'b1);
      step(1, 0, 8'h90, 1, 0, 0); check_state("halt.t3", 8'h24, 4'd1, 1'b0, 1'b0, 1'b1);
      step(0, 0, 8'h00, 0, 0, 1); check_state("halt.t4", 8'h24, 4'd1, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-call
      EN = 1'b1; CALL = 1'b1; TARGET = 8'hA0; HALT = 1'b0;
      #1;
      RST_N = 1'b0;
      #1;
      check_state("async", 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b1;
      step(1, 0, 8'h00, 0, 0, 0); check_state("post", 8'h04, 4'd0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
